// File: rtl/msg_channel_arbiter.sv
// Two-producer message channel arbiter: one-entry holding register per
// producer, round-robin grant into a shared FIFO, credit-based flow control.
module msg_channel_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_we,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_we,
  output logic             req1_ready,
  output logic [WIDTH-1:0] fifo_wdata,
  output logic             fifo_we,
  input  logic             fifo_rd,
  output logic [CW-1:0]    credit,
  output logic             grant_id,
  output logic [1:0]       ovf,
  input  logic [1:0]       clr_ovf,
  output logic             err
);

  logic             pend0;
  logic             pend1;
  logic [WIDTH-1:0] hold0;
  logic [WIDTH-1:0] hold1;

  logic       grant_valid;
  logic       grant_sel;
  logic       grant0;
  logic       grant1;
  logic       credit_full;
  logic       credit_ret;
  logic [1:0] ovf_set;

  assign req0_ready = ~pend0;
  assign req1_ready = ~pend1;

  // Round-robin grant decision, credit return qualification and overflow detection
  always_comb begin
    grant_valid = (credit != '0) && (pend0 || pend1);
    grant_sel   = (pend0 && pend1) ? ~grant_id : pend1;
    grant0      = grant_valid && !grant_sel;
    grant1      = grant_valid && grant_sel;
    credit_full = (credit == CW'(DEPTH));
    // A read at full credit only counts when a grant consumes a slot at the same edge
    credit_ret  = fifo_rd && !(credit_full && !grant_valid);
    ovf_set[0]  = req0_we && pend0 && !grant0;
    ovf_set[1]  = req1_we && pend1 && !grant1;
  end

  // Holding registers: capture, recapture on same-edge grant, drain on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (req0_we && (!pend0 || grant0)) begin
        hold0 <= req0_data;
        pend0 <= 1'b1;
      end else if (grant0) begin
        pend0 <= 1'b0;
      end
      if (req1_we && (!pend1 || grant1)) begin
        hold1 <= req1_data;
        pend1 <= 1'b1;
      end else if (grant1) begin
        pend1 <= 1'b0;
      end
    end
  end

  // FIFO write port and last-grant tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_we    <= 1'b0;
      fifo_wdata <= '0;
      grant_id   <= 1'b1;
    end else begin
      fifo_we <= grant_valid;
      if (grant_valid) begin
        fifo_wdata <= grant_sel ? hold1 : hold0;
        grant_id   <= grant_sel;
      end
    end
  end

  // Credit counter: grants consume, consumer reads return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CW'(DEPTH);
    end else begin
      unique case ({grant_valid, credit_ret})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  // Sticky status: per-producer overflow (set beats clear) and spurious-read error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
      err <= 1'b0;
    end else begin
      ovf <= (ovf & ~clr_ovf) | ovf_set;
      if (fifo_rd && credit_full && !grant_valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msg_channel_arbiter.sv
// Bench for msg_channel_arbiter: queue/array model checked every cycle plus
// literal expectations from directed scenarios.
module tb_msg_channel_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] req0_data;
  logic             req0_we;
  logic             req0_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req1_we;
  logic             req1_ready;
  logic [WIDTH-1:0] fifo_wdata;
  logic             fifo_we;
  logic             fifo_rd;
  logic [CW-1:0]    credit;
  logic             grant_id;
  logic [1:0]       ovf;
  logic [1:0]       clr_ovf;
  logic             err;

  msg_channel_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_data  (req0_data),
    .req0_we    (req0_we),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_we    (req1_we),
    .req1_ready (req1_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_we    (fifo_we),
    .fifo_rd    (fifo_rd),
    .credit     (credit),
    .grant_id   (grant_id),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who holds a word, how many free slots, what was written last
  bit          m_pend [2];
  logic [31:0] m_hold [2];
  int          m_credit = DEPTH;
  int          m_last   = 1;
  bit          m_we     = 0;
  logic [31:0] m_wdata  = '0;
  logic [1:0]  m_ovf    = '0;
  bit          m_err    = 0;
  logic [31:0] wr_q[$];
  int          g;
  int          old_credit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_hold[0] = '0; m_hold[1] = '0;
      m_credit = DEPTH; m_last = 1;
      m_we = 0; m_wdata = '0; m_ovf = '0; m_err = 0;
    end else begin
      old_credit = m_credit;
      // Pick a winner: nobody without credit; else the only waiter, or the one not served last
      g = -1;
      if (m_credit > 0) begin
        if (m_pend[0] && m_pend[1]) g = 1 - m_last;
        else if (m_pend[0])         g = 0;
        else if (m_pend[1])         g = 1;
      end
      if (g >= 0) begin
        m_we = 1; m_wdata = m_hold[g]; m_last = g; m_pend[g] = 0;
        wr_q.push_back(m_hold[g]);
        m_credit = m_credit - 1;
      end else begin
        m_we = 0;
      end
      if (fifo_rd) begin
        if (old_credit == DEPTH && g < 0) m_err = 1;
        else m_credit = m_credit + 1;
      end
      m_ovf = m_ovf & ~clr_ovf;
      // Slot still occupied after the grant drained it means the new word is lost
      if (req0_we) begin
        if (m_pend[0]) m_ovf[0] = 1'b1;
        else begin m_hold[0] = req0_data; m_pend[0] = 1; end
      end
      if (req1_we) begin
        if (m_pend[1]) m_ovf[1] = 1'b1;
        else begin m_hold[1] = req1_data; m_pend[1] = 1; end
      end
    end
  end

  // Compare process: every cycle once out of the initial reset
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_credit", credit, m_credit);
      chk("model_fifo_we", fifo_we, m_we);
      if (m_we) chk("model_fifo_wdata", fifo_wdata, m_wdata);
      chk("model_grant_id", grant_id, m_last);
      chk("model_ready0", req0_ready, !m_pend[0]);
      chk("model_ready1", req1_ready, !m_pend[1]);
      chk("model_ovf", ovf, m_ovf);
      chk("model_err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic strobe(input bit p0, input logic [31:0] d0, input bit p1, input logic [31:0] d1);
    req0_data = d0; req0_we = p0;
    req1_data = d1; req1_we = p1;
    tick();
    req0_we = 1'b0; req1_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_data = '0; req0_we = 1'b0;
    req1_data = '0; req1_we = 1'b0;
    fifo_rd = 1'b0; clr_ovf = '0;
    repeat (2) tick();

    // Reset values
    chk("rst_credit", credit, 8);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b11);
    chk("rst_fifo_we", fifo_we, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_grant_id", grant_id, 1);
    rst_n = 1'b1;
    chk_en = 1;

    // Single write: visible on the FIFO port the cycle after the holding edge
    strobe(1, 32'hA5, 0, 0);
    chk("single_ready0", req0_ready, 0);
    chk("single_we_early", fifo_we, 0);
    tick();
    chk("single_we", fifo_we, 1);
    chk("single_wdata", fifo_wdata, 32'hA5);
    chk("single_credit", credit, 7);
    chk("single_grant", grant_id, 0);
    tick();
    chk("single_we_drop", fifo_we, 0);

    // Ties from reset: producer 0 first, then alternation keeps it first next tie
    do_reset();
    wr_q.delete();
    strobe(1, 32'h11, 1, 32'h22);
    tick();
    chk("tie1_first", fifo_wdata, 32'h11);
    tick();
    chk("tie1_second", fifo_wdata, 32'h22);
    chk("tie1_credit", credit, 6);
    tick();
    strobe(1, 32'h33, 1, 32'h44);
    tick(); tick();
    chk("tie_order_len", wr_q.size(), 4);
    chk("tie_order", {wr_q[0][7:0], wr_q[1][7:0], wr_q[2][7:0], wr_q[3][7:0]}, 32'h11223344);
    chk("tie2_credit", credit, 4);

    // Credit exhaustion: ninth word stays held until a slot frees
    do_reset();
    for (int k = 0; k < 9; k++) begin
      strobe(1, 32'h100 + k, 0, 0);
      tick();
      tick();
    end
    chk("starve_credit", credit, 0);
    chk("starve_ready0", req0_ready, 0);
    chk("starve_we", fifo_we, 0);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("starve_credit_ret", credit, 1);
    tick();
    chk("starve_we9", fifo_we, 1);
    chk("starve_wdata9", fifo_wdata, 32'h108);
    chk("starve_credit0", credit, 0);

    // Overflow while starved, clear, and set-beats-clear on the same edge
    strobe(1, 32'h200, 0, 0);
    chk("ovf_ready0", req0_ready, 0);
    strobe(1, 32'h201, 0, 0);
    chk("ovf_p0", ovf, 2'b01);
    clr_ovf = 2'b01;
    tick();
    clr_ovf = 2'b00;
    chk("ovf_clr", ovf, 2'b00);
    strobe(0, 0, 1, 32'h300);
    strobe(0, 0, 1, 32'h301);
    chk("ovf_p1", ovf, 2'b10);
    clr_ovf = 2'b10;
    strobe(0, 0, 1, 32'h302);
    clr_ovf = 2'b00;
    chk("ovf_set_wins", ovf, 2'b10);
    clr_ovf = 2'b10;
    tick();
    clr_ovf = 2'b00;
    chk("ovf_clr_p1", ovf, 2'b00);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    tick();
    chk("drop_kept_p1", fifo_wdata, 32'h300);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    tick();
    chk("drop_kept_p0", fifo_wdata, 32'h200);

    // Grant and read on the same edge; spurious read at full credit
    do_reset();
    strobe(1, 32'h55, 0, 0);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("bal_credit", credit, 8);
    chk("bal_we", fifo_we, 1);
    chk("bal_err", err, 0);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("err_set", err, 1);
    chk("err_credit", credit, 8);
    tick();
    chk("err_sticky", err, 1);

    // Recapture at the grant edge, then reset mid-operation discards held word
    do_reset();
    chk("rst_err_clr", err, 0);
    strobe(1, 32'h61, 0, 0);
    strobe(1, 32'h62, 0, 0);
    chk("recap_wdata", fifo_wdata, 32'h61);
    chk("recap_ovf", ovf, 0);
    chk("recap_ready0", req0_ready, 0);
    tick();
    chk("recap_wdata2", fifo_wdata, 32'h62);
    strobe(1, 32'h77, 0, 0);
    do_reset();
    chk("midrst_ready0", req0_ready, 1);
    tick();
    chk("midrst_no_write", fifo_we, 0);
    tick();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
